// File: rtl/fft_outbuf_pkg.sv
// Shared types and constants for the FFT ping-pong output buffer.
//   rd_state_e : read-side FSM states
//   FifoDepth  : entries in the output skid FIFO
//   RamLatency : RAM read latency in cycles
package fft_outbuf_pkg;

  typedef enum logic [1:0] {
    RdIdle,
    RdRun,
    RdDrain
  } rd_state_e;

  localparam int unsigned FifoDepth  = 2;
  localparam int unsigned RamLatency = 1;

endpackage

// File: rtl/fft_outbuf_ram2p.sv
// Simple dual-port RAM, one write port and one read port, registered read data.
//   clk_i          : clock
//   we_i           : write enable
//   waddr_i/wdata_i: write address / data
//   raddr_i        : read address, sampled every cycle
//   rdata_o        : read data, valid one cycle after raddr_i
// Contents are not reset.
module fft_outbuf_ram2p #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_pingpong_outbuf.sv
// Ping-pong output buffer for an FFT core. The writer fills one bank with P/Q pairs
// (P at sample wA, Q at sample wA+PTS/2) and commits it on wLast; the reader streams a
// committed bank through a 2-entry skid FIFO with a valid/ready handshake.
// Ports:
//   clk, nGrst                : clock, synchronous active-low reset
//   wEn, wA, inP, inQ, wLast  : pair write interface
//   outD, outValid, outReady  : streamed sample and handshake
//   outFirst, outLast         : frame delimiters aligned with outD
//   bankFull                  : per-bank committed-and-unread flags
//   overflow                  : sticky flag, set when a write hits a full bank
// Build option: define FFT_OUTBUF_BITREV_EN to bit-reverse the read index (natural-order
// output from bit-reversed writes).
module fft_pingpong_outbuf
  import fft_outbuf_pkg::*;
#(
  parameter int unsigned LOGPTS = 8,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              nGrst,
  input  logic              wEn,
  input  logic [LOGPTS-2:0] wA,
  input  logic [DWIDTH-1:0] inP,
  input  logic [DWIDTH-1:0] inQ,
  input  logic              wLast,
  output logic [DWIDTH-1:0] outD,
  output logic              outValid,
  input  logic              outReady,
  output logic              outFirst,
  output logic              outLast,
  output logic [1:0]        bankFull,
  output logic              overflow
);

  localparam int unsigned AW = LOGPTS - 1;

  // Write side
  logic       wb_q, wb_d;
  logic [1:0] bank_full_q, bank_full_d;
  logic       overflow_q, overflow_d;
  logic       wr_ok, commit;

  // Read side
  rd_state_e         state_q, state_d;
  logic              rb_q, rb_d;
  logic [LOGPTS-1:0] rc_q, rc_d;
  logic [LOGPTS-1:0] rd_idx;
  logic              issue, issue_bank, credit, pop, release_bank;
  logic              rd_vld_q, rd_bank_q, rd_sel_q, rd_first_q, rd_last_q;
  logic              rd_vld_d, rd_bank_d, rd_sel_d, rd_first_d, rd_last_d;
  logic [DWIDTH-1:0] ram_rdata [2][2];
  logic [DWIDTH-1:0] rd_word;

  // Output FIFO: entry = {first, last, data}
  logic [DWIDTH+1:0] fifo_mem_q [FifoDepth];
  logic [DWIDTH+1:0] fifo_mem_d [FifoDepth];
  logic              fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [DWIDTH+1:0] head;
  logic [2:0]        occ;

  assign wr_ok  = wEn & ~bank_full_q[wb_q];
  assign commit = wr_ok & wLast;

  assign head         = fifo_mem_q[fifo_rd_q];
  assign outValid     = (fifo_cnt_q != 2'd0);
  assign pop          = outValid & outReady;
  assign release_bank = pop & head[DWIDTH];

  // Occupancy after this cycle's push/pop; a read issued now lands in the FIFO next cycle.
  assign occ    = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign credit = (occ < 3'(FifoDepth));

  always_comb begin
    wb_d        = wb_q;
    bank_full_d = bank_full_q;
    overflow_d  = overflow_q | (wEn & bank_full_q[wb_q]);
    if (commit) begin
      bank_full_d[wb_q] = 1'b1;
      wb_d              = ~wb_q;
    end
    if (release_bank) begin
      bank_full_d[rb_q] = 1'b0;
    end
  end

  always_comb begin
    rd_idx = '0;
`ifdef FFT_OUTBUF_BITREV_EN
    for (int i = 0; i < LOGPTS; i++) begin
      rd_idx[i] = rc_q[LOGPTS-1-i];
    end
`else
    rd_idx = rc_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    rb_d       = rb_q;
    rc_d       = rc_q;
    issue      = 1'b0;
    issue_bank = rb_q;
    unique case (state_q)
      RdIdle: begin
        if (bank_full_q[rb_q]) begin
          state_d = RdRun;
          rc_d    = '0;
        end
      end
      RdRun: begin
        if (credit) begin
          issue = 1'b1;
          rc_d  = rc_q + 1'b1;
          if (rc_q == '1) begin
            state_d = RdDrain;
          end
        end
      end
      RdDrain: begin
        // Prefetch the other bank while the tail drains so back-to-back frames have no gap.
        issue_bank = ~rb_q;
        if (credit && bank_full_q[~rb_q]) begin
          issue = 1'b1;
          rc_d  = rc_q + 1'b1;
        end
        if (release_bank) begin
          rb_d    = ~rb_q;
          state_d = bank_full_d[~rb_q] ? RdRun : RdIdle;
        end
      end
      default: state_d = RdIdle;
    endcase
  end

  assign rd_vld_d   = issue;
  assign rd_bank_d  = issue_bank;
  assign rd_sel_d   = rd_idx[LOGPTS-1];
  assign rd_first_d = (rc_q == '0);
  assign rd_last_d  = (rc_q == '1);
  assign rd_word    = ram_rdata[rd_bank_q][rd_sel_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BankId = 1'(b);
    for (genvar q = 0; q < 2; q++) begin : g_half
      fft_outbuf_ram2p #(
        .AW(AW),
        .DW(DWIDTH)
      ) u_ram (
        .clk_i  (clk),
        .we_i   (wr_ok & (wb_q == BankId)),
        .waddr_i(wA),
        .wdata_i((q == 0) ? inP : inQ),
        .raddr_i(rd_idx[AW-1:0]),
        .rdata_o(ram_rdata[b][q])
      );
    end
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (rd_vld_q) begin
      fifo_mem_d[fifo_wr_q] = {rd_first_q, rd_last_q, rd_word};
    end
    fifo_wr_d  = fifo_wr_q ^ rd_vld_q;
    fifo_rd_d  = fifo_rd_q ^ pop;
    fifo_cnt_d = fifo_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!nGrst) begin
      wb_q        <= 1'b0;
      bank_full_q <= 2'b00;
      overflow_q  <= 1'b0;
      state_q     <= RdIdle;
      rb_q        <= 1'b0;
      rc_q        <= '0;
      rd_vld_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      wb_q        <= wb_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      rb_q        <= rb_d;
      rc_q        <= rc_d;
      rd_vld_q    <= rd_vld_d;
      rd_bank_q   <= rd_bank_d;
      rd_sel_q    <= rd_sel_d;
      rd_first_q  <= rd_first_d;
      rd_last_q   <= rd_last_d;
      fifo_mem_q  <= fifo_mem_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  assign outD     = head[DWIDTH-1:0];
  assign outFirst = outValid & head[DWIDTH+1];
  assign outLast  = outValid & head[DWIDTH];
  assign bankFull = bank_full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fft_pingpong_outbuf.sv
// Directed testbench for fft_pingpong_outbuf with LOGPTS=4 (16-sample frames).
module tb_fft_pingpong_outbuf;

  localparam int unsigned LOGPTS = 4;
  localparam int unsigned DWIDTH = 32;

  logic              clk = 1'b0;
  logic              nGrst = 1'b0;
  logic              wEn = 1'b0;
  logic [LOGPTS-2:0] wA = '0;
  logic [DWIDTH-1:0] inP = '0;
  logic [DWIDTH-1:0] inQ = '0;
  logic              wLast = 1'b0;
  logic [DWIDTH-1:0] outD;
  logic              outValid;
  logic              outReady = 1'b1;
  logic              outFirst;
  logic              outLast;
  logic [1:0]        bankFull;
  logic              overflow;

  fft_pingpong_outbuf #(
    .LOGPTS(LOGPTS),
    .DWIDTH(DWIDTH)
  ) dut (
    .clk     (clk),
    .nGrst   (nGrst),
    .wEn     (wEn),
    .wA      (wA),
    .inP     (inP),
    .inQ     (inQ),
    .wLast   (wLast),
    .outD    (outD),
    .outValid(outValid),
    .outReady(outReady),
    .outFirst(outFirst),
    .outLast (outLast),
    .bankFull(bankFull),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // outReady pattern: 0 = always 1, 1 = repeating 1,0,0,1, 2 = always 0
  int ready_mode = 0;
  int ready_cyc  = 0;
  logic [3:0] ready_pat = 4'b1001;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_cyc++;
      case (ready_mode)
        0:       outReady = 1'b1;
        1:       outReady = ready_pat[ready_cyc % 4];
        default: outReady = 1'b0;
      endcase
    end
  end

  // Monitor: record accepted samples, check hold while stalled, track longest valid run.
  logic [DWIDTH-1:0] got_d[$];
  logic              got_f[$];
  logic              got_l[$];
  logic              prev_stall = 1'b0;
  logic [DWIDTH-1:0] prev_d;
  logic              prev_f, prev_l;
  int                run_len = 0;
  int                max_run = 0;
  int                stall_cnt = 0;

  always @(negedge clk) begin
    if (!nGrst) begin
      prev_stall = 1'b0;
      run_len    = 0;
    end else begin
      if (prev_stall) begin
        check("hold", {29'd0, outValid, outFirst, outLast, outD},
              {29'd0, 1'b1, prev_f, prev_l, prev_d});
      end
      if (outValid && outReady) begin
        got_d.push_back(outD);
        got_f.push_back(outFirst);
        got_l.push_back(outLast);
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (outValid && !outReady) stall_cnt++;
      prev_stall = outValid && !outReady;
      prev_d     = outD;
      prev_f     = outFirst;
      prev_l     = outLast;
    end
  end

  logic [DWIDTH-1:0] exp_d[$];

  task automatic clear_got();
    got_d.delete();
    got_f.delete();
    got_l.delete();
    exp_d.delete();
  endtask

  task automatic expect_frame(input int bp, input int bq);
    for (int k = 0; k < 8; k++) exp_d.push_back(DWIDTH'(bp + k));
    for (int k = 0; k < 8; k++) exp_d.push_back(DWIDTH'(bq + k));
  endtask

  // Called at posedge+1; returns at posedge+1 with the write strobe dropped.
  task automatic write_frame(input int bp, input int bq);
    for (int k = 0; k < 8; k++) begin
      wEn   = 1'b1;
      wA    = (LOGPTS-1)'(k);
      inP   = DWIDTH'(bp + k);
      inQ   = DWIDTH'(bq + k);
      wLast = (k == 7);
      @(posedge clk);
      #1;
    end
    wEn   = 1'b0;
    wLast = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int n, input int budget);
    int cyc = 0;
    while (got_d.size() < n && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(tag, got_d.size(), n);
  endtask

  task automatic check_stream(input string tag);
    int n;
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, got_d[i], exp_d[i]);
      check({tag, "_first"}, got_f[i], (i % 16) == 0);
      check({tag, "_last"}, got_l[i], (i % 16) == 15);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

`ifdef FFT_OUTBUF_BITREV_EN
  function automatic int bitrev4(input int v);
    logic [3:0] a, r;
    a = 4'(v);
    for (int i = 0; i < 4; i++) r[i] = a[3-i];
    return int'(r);
  endfunction
`endif

  initial begin
    // Reset
    idle(2);
    nGrst = 1'b1;
    idle(1);
    check("rst_valid", outValid, 0);
    check("rst_outd", outD, 0);
    check("rst_bankfull", bankFull, 0);
    check("rst_overflow", overflow, 0);

    // Single frame, full throughput
    clear_got();
    expect_frame(0, 100);
    write_frame(0, 100);
    wait_count("t1_count", 16, 100);
    idle(10);
    check("t1_no_extra", got_d.size(), 16);
    check_stream("t1");
    check("t1_bankfull", bankFull, 0);

    // Two frames back-to-back: 32 consecutive valid cycles
    clear_got();
    max_run = 0;
    expect_frame(0, 100);
    expect_frame(200, 300);
    write_frame(0, 100);
    write_frame(200, 300);
    wait_count("t2_count", 32, 200);
    idle(10);
    check_stream("t2");
    check("t2_run", max_run, 32);
    check("t2_bankfull", bankFull, 0);

    // Backpressure 1,0,0,1
    clear_got();
    stall_cnt  = 0;
    ready_mode = 1;
    expect_frame(0, 100);
    write_frame(0, 100);
    wait_count("t3_count", 16, 300);
    idle(10);
    check("t3_no_extra", got_d.size(), 16);
    check_stream("t3");
    check("t3_stalled", stall_cnt > 0, 1);
    ready_mode = 0;
    idle(4);

    // Three frames with outReady=0: third dropped, overflow set
    clear_got();
    ready_mode = 2;
    idle(2);
    expect_frame(0, 100);
    expect_frame(200, 300);
    write_frame(0, 100);
    write_frame(200, 300);
    write_frame(400, 500);
    idle(4);
    check("t4_full", bankFull, 3);
    check("t4_overflow", overflow, 1);
    check("t4_none_out", got_d.size(), 0);
    ready_mode = 0;
    wait_count("t4_count", 32, 300);
    idle(20);
    check("t4_no_extra", got_d.size(), 32);
    check_stream("t4");
    check("t4_bankfull", bankFull, 0);
    check("t4_overflow_sticky", overflow, 1);

    // Reset mid-stream after sample 5
    clear_got();
    write_frame(0, 100);
    wait_count("t5_pre", 6, 100);
    nGrst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_valid", outValid, 0);
    check("t5_outd", outD, 0);
    check("t5_first", outFirst, 0);
    check("t5_last", outLast, 0);
    check("t5_bankfull", bankFull, 0);
    check("t5_overflow", overflow, 0);
    nGrst = 1'b1;
    idle(2);
    clear_got();
    expect_frame(500, 600);
    write_frame(500, 600);
    wait_count("t5_count", 16, 100);
    idle(10);
    check("t5_no_extra", got_d.size(), 16);
    check_stream("t5");

`ifdef FFT_OUTBUF_BITREV_EN
    // Bit-reversed writes come out in natural order
    clear_got();
    for (int m = 0; m < 16; m++) exp_d.push_back(DWIDTH'(m));
    for (int k = 0; k < 8; k++) begin
      wEn   = 1'b1;
      wA    = (LOGPTS-1)'(k);
      inP   = DWIDTH'(bitrev4(k));
      inQ   = DWIDTH'(bitrev4(k + 8));
      wLast = (k == 7);
      @(posedge clk);
      #1;
    end
    wEn   = 1'b0;
    wLast = 1'b0;
    wait_count("t6_count", 16, 100);
    check_stream("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_pingpong_outbuf.md
FFT_PINGPONG_OUTBUF -- requirements
Module: fft_pingpong_outbuf

Interface
REQ-001 LOGPTS, default 8, log2 of frame length PTS; each bank holds PTS/2 P-words and PTS/2 Q-words.
REQ-002 DWIDTH, default 32, complex word width (re and im packed).
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 nGrst  in  1  reset; synchronous and active-low.
REQ-005 wEn  in  1  write strobe for one P/Q pair.
REQ-006 wA  in  LOGPTS-1  pair write address.
REQ-007 inP, inQ  in  DWIDTH each  pair data; P goes to sample wA, Q to sample wA+PTS/2.
REQ-008 wLast  in  1  qualifies wEn; marks final pair of the frame and commits the write bank.
REQ-009 outD  out  DWIDTH  streamed sample.
REQ-010 outValid  out  1  / outReady  in  1  valid/ready output handshake.
REQ-011 outFirst, outLast  out  1 each  frame delimiters, aligned with outD.
REQ-012 bankFull  out  2  per-bank committed-and-unread flags.
REQ-013 overflow  out  1  sticky dropped-write flag.

Function
REQ-014 Two banks; write-bank pointer wb and read-bank pointer rb, both 0 after reset.
REQ-015 wEn with bankFull[wb]=0 writes the pair into bank wb at wA in the next cycle.
REQ-016 wEn with wLast and bankFull[wb]=0 sets bankFull[wb] and toggles wb in the same edge.
REQ-017 wEn with bankFull[wb]=1 is dropped, and overflow is set; overflow clears only on reset.
REQ-018 The read FSM has states RD_IDLE, RD_RUN and RD_DRAIN.
REQ-019 RD_IDLE: go to RD_RUN when bankFull[rb]=1, with read counter rc=0.
REQ-020 RD_RUN: each cycle a credit is free, issue read rc and increment rc.
REQ-021 rc MSB selects Q (1) or P (0); rc LSBs form the RAM address.
REQ-022 RD_RUN: after issuing rc=PTS-1, go to RD_DRAIN.
REQ-023 RD_DRAIN: when the word with rc=PTS-1 is accepted, clear bankFull[rb] and toggle rb.
REQ-024 From RD_DRAIN, next state is RD_RUN if the new bankFull[rb]=1, else RD_IDLE; no idle bubble between back-to-back frames.
REQ-025 RAM read latency is 1 cycle, and outD is registered, so minimum read-issue to outValid is 2 cycles.
REQ-026 The output stage is a 2-entry skid FIFO.
REQ-027 A read issues only if FIFO occupancy plus in-flight reads is < 2, giving full throughput at outReady=1 and no loss under backpressure.
REQ-028 outD, outValid, outFirst and outLast hold stable while outValid=1 and outReady=0.
REQ-029 outFirst=1 on output sample 0 and outLast=1 on sample PTS-1.
REQ-030 Clearing bankFull[x] by the reader and setting bankFull[y] by the writer may occur in the same cycle; both take effect.
REQ-031 A commit to bank x in the same cycle as its release is impossible by construction, since the writer is blocked on full.
REQ-032 Writes to bank wb never corrupt bank rb during streaming.

Reset
REQ-033 nGrst=0 at a clock edge forces outValid, outFirst, outLast, bankFull, overflow, wb, rb and rc to 0, FSM to RD_IDLE and FIFO empty.
REQ-034 Reset mid-frame discards partial writes and the in-progress stream.
REQ-035 outD resets to 0.
REQ-036 RAM contents are not reset.

Configuration
REQ-037 The macro is FFT_OUTBUF_BITREV_EN.
REQ-038 Defined: sample index rc is bit-reversed over LOGPTS bits before the P/Q split, giving natural-order output from bit-reversed-order FFT writes.
REQ-039 Undefined: rc is used directly (natural addressing), with no reversal logic synthesised.
REQ-040 The handshake and latency are identical in both builds.

Structure
REQ-041 Package fft_outbuf_pkg holds the read FSM state enum, the FIFO depth constant (2) and the RAM latency constant (1).
REQ-042 One sub-module, fft_outbuf_ram2p: simple dual-port RAM, depth 2^(LOGPTS-1), width DWIDTH, 1-cycle registered read.
REQ-043 Four instances: 2 banks x P/Q.
REQ-044 The bank is selected by the high address bit or by instance mux.

Verification (LOGPTS=4, PTS=16)
REQ-045 Write pairs wA=0..7, inP=k, inQ=100+k, wLast on wA=7, with outReady=1 -> outD sequence 0..7,100..107; outFirst on 0, outLast on 107; bankFull returns to 00.
REQ-046 Two frames back-to-back (second inP=200+k), outReady=1 -> 32 consecutive outValid cycles with no gap between 107 and 200.
REQ-047 With outReady toggled 1,0,0,1 repeatedly -> all 16 samples delivered in order, no duplicates, outD held stable while stalled.
REQ-048 Three frames written with outReady=0 -> bankFull=11, third-frame writes dropped, overflow=1; after draining, the output is frames 1 and 2 only.
REQ-049 nGrst pulsed after sample 5 has streamed -> all outputs 0 next cycle, and the next full frame streams correctly from sample 0.
REQ-050 With FFT_OUTBUF_BITREV_EN defined, write sample n=bitrev4(m) with value m -> output 0,1,...,15.
